// File: rtl/catch_game_if.sv
// Link between the catch-game controller and the LED datapath.
// Signalling: hit/miss are single-cycle pulses from the datapath, sampled on
// every clk edge with no back-pressure; tick is a single-cycle strobe from the
// controller. Every other field is a registered status level, valid every cycle.
interface catch_game_if;
    logic       hit;
    logic       miss;
    logic       tick;
    logic [2:0] state;
    logic [2:0] level;
    logic [1:0] lives;
    logic [6:0] score;
    logic       flash;
    logic       game_over;

    modport master (
        input  hit, miss,
        output tick, state, level, lives, score, flash, game_over
    );

    modport slave (
        output hit, miss,
        input  tick, state, level, lives, score, flash, game_over
    );
endinterface

// File: rtl/catch_game_ctrl.sv
// Game sequencer for the LED-catch datapath: start-button debounce,
// IDLE/PLAY/LEVEL_UP/OVER FSM, level-dependent shift tick, and the score,
// lives and level counters.
// Optional feature: define CATCH_PAUSE_EN to add the PAUSE state (press in
// PLAY freezes the game, press in PAUSE resumes it).
module catch_game_ctrl #(
    parameter int BASE_DIV       = 5_000_000,
    parameter int DIV_STEP       = 500_000,
    parameter int MAX_LEVEL      = 7,
    parameter int HITS_PER_LEVEL = 4,
    parameter int LIVES          = 3,
    parameter int FLASH_TICKS    = 4,
    parameter int DEB_CYCLES     = 1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_btn,
    catch_game_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLAY     = 3'd1,
        S_LEVEL_UP = 3'd2,
`ifdef CATCH_PAUSE_EN
        S_OVER     = 3'd3,
        S_PAUSE    = 3'd4
`else
        S_OVER     = 3'd3
`endif
    } state_t;

    localparam int HCW = $clog2(HITS_PER_LEVEL + 1);
    localparam int DCW = $clog2(DEB_CYCLES + 1);
    localparam int FCW = $clog2(FLASH_TICKS + 1);

    localparam logic [31:0] BASE_P     = 32'(BASE_DIV);
    localparam logic [31:0] STEP_P     = 32'(DIV_STEP);
    localparam logic [2:0]  MAX_L      = 3'(MAX_LEVEL);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
    localparam logic [HCW-1:0] HIT_LAST  = HCW'(HITS_PER_LEVEL - 1);
    localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEB_CYCLES - 1);
    localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_TICKS - 1);

    state_t         state_q, state_d;
    logic           btn_s1, btn_s2, btn_deb, btn_deb_q, press;
    logic [DCW-1:0] deb_cnt;
    logic [31:0]    div_cnt, period;
    logic           wrap, div_clear, pause_edge;
    logic [FCW-1:0] flash_cnt;
    logic [HCW-1:0] hit_cnt;
    logic [2:0]     level_q;
    logic [1:0]     lives_q;
    logic [6:0]     score_q;
    logic           tick_q, flash_q, over_q;
    logic           do_init, do_hit, do_miss, do_level;

    // Synchronise the raw button, then accept a new level only after it has
    // differed from the debounced value for DEB_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1    <= 1'b0;
            btn_s2    <= 1'b0;
            btn_deb   <= 1'b0;
            btn_deb_q <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            btn_s1    <= start_btn;
            btn_s2    <= btn_s1;
            btn_deb_q <= btn_deb;
            if (btn_s2 == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                btn_deb <= btn_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign press = btn_deb & ~btn_deb_q;

    // Tick period shrinks with level in PLAY; LEVEL_UP always times in base periods.
    assign period = (state_q == S_LEVEL_UP) ? BASE_P : (BASE_P - 32'(level_q) * STEP_P);
    assign wrap   = (div_cnt == period - 32'd1);

`ifdef CATCH_PAUSE_EN
    assign pause_edge = (state_q == S_PAUSE) || (state_d == S_PAUSE);
`else
    assign pause_edge = 1'b0;
`endif
    // PLAY<->PAUSE keeps the divider count so the game resumes mid-period.
    assign div_clear = (state_d != state_q) && !pause_edge;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and the per-cycle counter update requests.
    always_comb begin
        state_d  = state_q;
        do_init  = 1'b0;
        do_hit   = 1'b0;
        do_miss  = 1'b0;
        do_level = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (press) begin
                    state_d = S_PLAY;
                    do_init = 1'b1;
                end
            end
            S_PLAY: begin
`ifdef CATCH_PAUSE_EN
                if (press) state_d = S_PAUSE;
                else
`endif
                if (bus.miss) begin
                    // A simultaneous hit is dropped: the miss wins.
                    do_miss = 1'b1;
                    if (lives_q == 2'd1) state_d = S_OVER;
                end else if (bus.hit) begin
                    do_hit = 1'b1;
                    if (hit_cnt == HIT_LAST && level_q < MAX_L) state_d = S_LEVEL_UP;
                end
            end
            S_LEVEL_UP: begin
                if (wrap && flash_cnt == FLASH_LAST) begin
                    state_d  = S_PLAY;
                    do_level = 1'b1;
                end
            end
`ifdef CATCH_PAUSE_EN
            S_PAUSE: begin
                if (press) state_d = S_PLAY;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Divider, flash timer, game counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            flash_cnt <= '0;
            hit_cnt   <= '0;
            level_q   <= '0;
            lives_q   <= LIVES_INIT;
            score_q   <= '0;
            tick_q    <= 1'b0;
            flash_q   <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            tick_q  <= (state_q == S_PLAY) && (state_d == S_PLAY) && wrap;
            flash_q <= (state_d == S_LEVEL_UP);
            over_q  <= (state_d == S_OVER);

            if (div_clear) begin
                div_cnt <= '0;
            end else if (state_q == S_PLAY || state_q == S_LEVEL_UP) begin
                div_cnt <= wrap ? 32'd0 : div_cnt + 32'd1;
            end

            if (state_q != S_LEVEL_UP || state_d != S_LEVEL_UP) flash_cnt <= '0;
            else if (wrap)                                       flash_cnt <= flash_cnt + 1'b1;

            if (do_init) begin
                score_q <= '0;
                lives_q <= LIVES_INIT;
                level_q <= '0;
                hit_cnt <= '0;
            end
            if (do_miss) lives_q <= lives_q - 2'd1;
            if (do_hit) begin
                if (score_q != 7'd127) score_q <= score_q + 7'd1;
                // Zero on reaching the quota: wraps at MAX_LEVEL, and is the
                // fresh count for the next level otherwise.
                hit_cnt <= (hit_cnt == HIT_LAST) ? '0 : hit_cnt + 1'b1;
            end
            if (do_level) begin
                level_q <= level_q + 3'd1;
                hit_cnt <= '0;
            end
        end
    end

    assign bus.tick      = tick_q;
    assign bus.state     = state_q;
    assign bus.level     = level_q;
    assign bus.lives     = lives_q;
    assign bus.score     = score_q;
    assign bus.flash     = flash_q;
    assign bus.game_over = over_q;

endmodule
